// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared screen constants, plot request struct, sink state encoding
package pixel_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_DEPTH  = SCREEN_W * SCREEN_H;
  localparam int FB_ADDR_W = 15;
  localparam int COLOR_W   = 3;

  typedef struct packed {
    logic [7:0]         x;
    logic [6:0]         y;
    logic [COLOR_W-1:0] color;
  } pixel_req_t;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} sink_state_t;

  // Linear framebuffer address y*160+x, built from shifts so no multiplier is needed.
  function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
    logic [FB_ADDR_W-1:0] yw;
    logic [FB_ADDR_W-1:0] xw;
    yw = {{(FB_ADDR_W-7){1'b0}}, y};
    xw = {{(FB_ADDR_W-8){1'b0}}, x};
    return (yw << 7) + (yw << 5) + xw;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - small synchronous FIFO with full/empty flags
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointers/occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_write_sink.sv
// rtl/pixel_write_sink.sv - plot requests to framebuffer strobes with clear sweep; option PIXEL_WRITE_SINK_TRANSPARENT_EN
module pixel_write_sink
  import pixel_pkg::*;
#(
  parameter int                 FIFO_DEPTH   = 4,
  parameter int                 X_MAX        = SCREEN_W,
  parameter int                 Y_MAX        = SCREEN_H,
  parameter logic [COLOR_W-1:0] TRANSP_COLOR = 3'b101
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 plot_valid,
  output logic                 plot_ready,
  input  logic [7:0]           plot_x,
  input  logic [6:0]           plot_y,
  input  logic [COLOR_W-1:0]   plot_color,
  input  logic                 clear_req,
  input  logic [COLOR_W-1:0]   clear_color,
  output logic                 busy,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  output logic                 fb_we,
  output logic [7:0]           drop_count
);

  sink_state_t          state_q, state_d;
  logic [COLOR_W-1:0]   clr_color_q, clr_color_d;
  logic [FB_ADDR_W-1:0] sweep_q, sweep_d;
  logic [7:0]           drop_q, drop_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0]   fb_data_q, fb_data_d;
  logic                 fb_we_q, fb_we_d;

  pixel_req_t in_req, head_req;
  logic       fifo_full, fifo_empty;
  logic       accept, in_range, push, pop, head_write;

  assign in_req     = '{x: plot_x, y: plot_y, color: plot_color};
  assign plot_ready = !reset && (state_q == RUN) && !fifo_full;
  assign accept     = plot_valid && plot_ready;
  assign in_range   = (plot_x < 8'(X_MAX)) && (plot_y < 7'(Y_MAX));
  assign push       = accept && in_range;
  // No new requests enter during DRAIN/CLEAR, so the FIFO is already empty in CLEAR.
  assign pop        = !fifo_empty && (state_q != CLEAR);

`ifdef PIXEL_WRITE_SINK_TRANSPARENT_EN
  assign head_write = (head_req.color != TRANSP_COLOR);
`else
  logic unused_transp;
  assign unused_transp = ^TRANSP_COLOR;
  assign head_write    = 1'b1;
`endif

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_req_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (in_req),
    .pop       (pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State sequencing, drop counting and the next framebuffer write (plot or sweep).
  always_comb begin
    state_d     = state_q;
    clr_color_d = clr_color_q;
    sweep_d     = sweep_q;
    drop_d      = drop_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    fb_we_d     = 1'b0;

    if (accept && !in_range && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      RUN: begin
        if (clear_req) begin
          clr_color_d = clear_color;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !fb_we_q) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      CLEAR: begin
        // One extra cycle past the last address keeps plot_ready low until the final sweep write is visible.
        if (sweep_q == FB_ADDR_W'(FB_DEPTH)) begin
          state_d = RUN;
          sweep_d = '0;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = sweep_q;
          fb_data_d = clr_color_q;
          sweep_d   = sweep_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (pop && head_write) begin
      fb_we_d   = 1'b1;
      fb_addr_d = pixel_addr(head_req.x, head_req.y);
      fb_data_d = head_req.color;
    end
  end

  // Control and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      clr_color_q <= '0;
      sweep_q     <= '0;
      drop_q      <= '0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      fb_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_color_q <= clr_color_d;
      sweep_q     <= sweep_d;
      drop_q      <= drop_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      fb_we_q     <= fb_we_d;
    end
  end

  assign busy       = (state_q != RUN) || !fifo_empty || fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// tb/tb_pixel_write_sink.sv - self-checking bench for pixel_write_sink against a queue-based write model
module tb_pixel_write_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        plot_valid;
  logic        plot_ready;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_color;
  logic        clear_req;
  logic [2:0]  clear_color;
  logic        busy;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_drop = 0;
  int write_count = 0;

  always #5 clk = ~clk;

  pixel_write_sink dut (
    .clk         (clk),
    .reset       (reset),
    .plot_valid  (plot_valid),
    .plot_ready  (plot_ready),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_color  (plot_color),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .busy        (busy),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .drop_count  (drop_count)
  );

  function automatic bit is_transparent(input logic [2:0] c);
`ifdef PIXEL_WRITE_SINK_TRANSPARENT_EN
    return c == 3'b101;
`else
    return c == 3'b000 && c != 3'b000;
`endif
  endfunction

  // Reference model: every accepted in-range, non-transparent plot becomes one write of y*160+x.
  always @(negedge clk) begin
    if (!reset) begin
      if (plot_valid && plot_ready) begin
        if (int'(plot_x) >= 160 || int'(plot_y) >= 120) begin
          exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
        end else if (!is_transparent(plot_color)) begin
          exp_addr_q.push_back(int'(plot_y) * 160 + int'(plot_x));
          exp_data_q.push_back(int'(plot_color));
        end
      end
      if (fb_we === 1'b1) begin
        write_count++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%0d required no write", fb_addr, fb_data);
        end else begin
          if (int'(fb_addr) !== exp_addr_q[0] || int'(fb_data) !== exp_data_q[0]) begin
            errors++;
            $display("FAIL write_content addr=%0d data=%0d required addr=%0d data=%0d",
                     fb_addr, fb_data, exp_addr_q[0], exp_data_q[0]);
          end
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; plot_valid = 1'b0; plot_x = '0; plot_y = '0; plot_color = '0;
    clear_req = 1'b0; clear_color = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 15'd0 || fb_data !== 3'd0 || drop_count !== 8'd0 ||
        busy !== 1'b0 || plot_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs we=%b addr=%0d data=%0d drop=%0d busy=%b ready=%b required all 0",
               fb_we, fb_addr, fb_data, drop_count, busy, plot_ready);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (plot_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset ready=%b busy=%b required ready=1 busy=0", plot_ready, busy);
    end
  endtask

  task automatic test_single_plot();
    @(posedge clk); #1;
    plot_valid = 1'b1; plot_x = 8'd5; plot_y = 7'd2; plot_color = 3'b011;
    @(negedge clk); #1;
    checks++;
    if (plot_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready ready=%b required 1", plot_ready);
    end
    @(posedge clk); #1;
    plot_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL single_early we=%b required 0 at N+1", fb_we);
    end
    @(negedge clk); #1;
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd325 || fb_data !== 3'b011) begin
      errors++;
      $display("FAIL single_write we=%b addr=%0d data=%0d required we=1 addr=325 data=3", fb_we, fb_addr, fb_data);
    end
    @(negedge clk); #1;
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 15'd325 || fb_data !== 3'b011) begin
      errors++;
      $display("FAIL single_hold we=%b addr=%0d data=%0d required we=0 addr=325 data=3", fb_we, fb_addr, fb_data);
    end
  endtask

  task automatic test_back_to_back();
    int addrs[$];
    int cyc[$];
    int ready_low = 0;
    int seq_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        plot_valid = 1'b1; plot_x = 8'(i); plot_y = 7'd119; plot_color = 3'(i);
      end else begin
        plot_valid = 1'b0;
      end
      @(negedge clk); #1;
      if (i < 8 && plot_ready !== 1'b1) ready_low++;
      if (fb_we === 1'b1) begin
        addrs.push_back(int'(fb_addr));
        cyc.push_back(i);
      end
    end
    checks++;
    if (ready_low != 0) begin
      errors++;
      $display("FAIL b2b_ready low_cycles=%0d required 0", ready_low);
    end
    checks++;
    if (addrs.size() != 8) begin
      errors++;
      $display("FAIL b2b_count writes=%0d required 8", addrs.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (addrs[k] != 19040 + k || cyc[k] != 2 + k) seq_bad++;
      end
      checks++;
      if (seq_bad != 0) begin
        errors++;
        $display("FAIL b2b_sequence bad=%0d first_addr=%0d first_cycle=%0d required 19040 at cycle 2, consecutive",
                 seq_bad, addrs[0], cyc[0]);
      end
    end
  endtask

  task automatic test_random();
    bit took = 1'b0;
    int n = 0;
    plot_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!(plot_valid && !took)) begin
        plot_valid = ($urandom_range(0, 3) != 0);
        plot_x     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
        plot_y     = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 119));
        plot_color = 3'($urandom_range(0, 7));
      end
      @(negedge clk); #1;
      took = plot_valid && plot_ready;
    end
    @(posedge clk); #1;
    plot_valid = 1'b0;
    while (exp_addr_q.size() > 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain pending=%0d required 0", exp_addr_q.size());
    end
    checks++;
    if (int'(drop_count) != exp_drop) begin
      errors++;
      $display("FAIL random_drop drop=%0d required %0d", drop_count, exp_drop);
    end
  endtask

  task automatic test_transparent();
    int wc;
    int exp_w;
    int drop0;
    @(posedge clk); #1;
    wc = write_count;
    drop0 = exp_drop;
    exp_w = is_transparent(3'b101) ? 0 : 1;
    plot_valid = 1'b1; plot_x = 8'd10; plot_y = 7'd10; plot_color = 3'b101;
    @(posedge clk); #1;
    plot_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (write_count - wc != exp_w) begin
      errors++;
      $display("FAIL transparent_writes got=%0d required %0d", write_count - wc, exp_w);
    end
    checks++;
    if (int'(drop_count) != drop0) begin
      errors++;
      $display("FAIL transparent_drop drop=%0d required %0d", drop_count, drop0);
    end
  endtask

  task automatic test_out_of_range();
    int wc;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_drop = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    wc = write_count;
    @(posedge clk); #1;
    plot_valid = 1'b1; plot_x = 8'd160; plot_y = 7'd0; plot_color = 3'd1;
    @(posedge clk); #1;
    plot_x = 8'd0; plot_y = 7'd120;
    @(posedge clk); #1;
    plot_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (write_count != wc || drop_count !== 8'd2) begin
      errors++;
      $display("FAIL oor_pair writes=%0d drop=%0d required writes=0 drop=2", write_count - wc, drop_count);
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      plot_valid = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        plot_x = 8'($urandom_range(160, 255)); plot_y = 7'($urandom_range(0, 127));
      end else begin
        plot_x = 8'($urandom_range(0, 255)); plot_y = 7'($urandom_range(120, 127));
      end
    end
    @(posedge clk); #1;
    plot_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (drop_count !== 8'd255 || exp_drop != 255 || write_count != wc) begin
      errors++;
      $display("FAIL oor_saturate drop=%0d writes=%0d required drop=255 writes=0", drop_count, write_count - wc);
    end
  endtask

  task automatic test_clear();
    int bad = 0;
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      plot_valid = 1'b1;
      plot_x     = 8'($urandom_range(0, 159));
      plot_y     = 7'($urandom_range(0, 119));
      plot_color = 3'($urandom_range(0, 7));
      if (i == 2) begin
        clear_req = 1'b1; clear_color = 3'b010;
      end
    end
    @(posedge clk); #1;
    plot_valid = 1'b0; clear_req = 1'b0; clear_color = 3'b111;
    for (int a = 0; a < 19200; a++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(2);
    end
    while (exp_addr_q.size() > 0 && n < 20000) begin
      @(negedge clk); #1;
      n++;
      if (plot_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (n == 1000 || n == 19100) begin
        clear_req = 1'b1; clear_color = 3'b110;
      end else begin
        clear_req = 1'b0;
      end
    end
    clear_req = 1'b0;
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL clear_timeout pending=%0d required 0", exp_addr_q.size());
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_flags bad_cycles=%0d required ready=0 busy=1 throughout", bad);
    end
    @(negedge clk); #1;
    checks++;
    if (plot_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_return ready=%b busy=%b required ready=1 busy=0", plot_ready, busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit found = 1'b0;
    int wc;
    @(posedge clk); #1;
    clear_req = 1'b1; clear_color = 3'b110;
    @(posedge clk); #1;
    clear_req = 1'b0;
    for (int a = 0; a < 19200; a++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(6);
    end
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk); #1;
      if (fb_we === 1'b1 && fb_addr === 15'd500) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midclear_reach addr=%0d required sweep to reach 500", fb_addr);
    end
    reset = 1'b1;
    #1;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_drop = 0;
    wc = write_count;
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 15'd0 || fb_data !== 3'd0 || busy !== 1'b0 ||
        drop_count !== 8'd0 || plot_ready !== 1'b0) begin
      errors++;
      $display("FAIL midclear_reset we=%b addr=%0d data=%0d busy=%b drop=%0d ready=%b required all 0",
               fb_we, fb_addr, fb_data, busy, drop_count, plot_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (plot_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midclear_resume ready=%b busy=%b required ready=1 busy=0", plot_ready, busy);
    end
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (write_count != wc) begin
      errors++;
      $display("FAIL midclear_nowrite writes=%0d required 0", write_count - wc);
    end
  endtask

  initial begin
    test_reset();
    test_single_plot();
    test_back_to_back();
    test_random();
    test_transparent();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
